vgm_axi_write_slave: RTL
========================

Name: vgm_axi_write_slave

Overview:
- AXI4 write-channel responder (slave end) backed by a small word-addressed memory.
- Accepts one AW burst at a time, sinks the W beats, and returns one B response per burst.
- Serves as the DUT-side counterpart for the team's AXI master agent. It also serves as a memory-model endpoint in block-level benches.
- A sideband debug read port exposes memory contents to the bench without using AXI reads.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR.
- DATA_WIDTH, 32, width of WDATA. Legal values are 32 or 64.
- ID_WIDTH, 4, width of AWID/BID.
- MEM_DEPTH, 16, number of DATA_WIDTH words in the backing memory. Must be a power of 2.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWID  in  ID_WIDTH  write address ID.
- AWADDR  in  ADDR_WIDTH  burst start byte address.
- AWLEN  in  8  beats minus 1.
- AWSIZE  in  3  log2 of bytes per beat.
- AWBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte strobes.
- WLAST  in  1  last beat of the burst.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BID  out  ID_WIDTH  response ID.
- BRESP  out  2  response: 00 OKAY, 10 SLVERR.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- dbg_addr  in  log2(MEM_DEPTH)  debug word index.
- dbg_data  out  DATA_WIDTH  mem[dbg_addr], registered, 1-cycle latency.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, dbg_data=0.
  - All memory words cleared to 0.
  - AWREADY rises on the first ACLK edge after ARESET deasserts.
- All AXI outputs are registered.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY=1.
  - On an AWVALID&AWREADY handshake, capture AWID, AWBURST, word index = AWADDR >> log2(DATA_WIDTH/8) (low address bits ignored), and beat count = AWLEN.
  - err flag is set if AWSIZE != log2(DATA_WIDTH/8) or AWBURST is not FIXED/INCR.
  - Next state DATA; AWREADY drops the following cycle.
- DATA:
  - WREADY=1; AWREADY=0. AW traffic stalls until the burst completes.
  - Each W handshake writes mem[idx] byte-wise under WSTRB, only if err=0 and idx < MEM_DEPTH.
  - A beat with idx >= MEM_DEPTH is dropped and sets err.
  - INCR: idx increments by 1 per beat. The index never wraps; past MEM_DEPTH it is out of range.
  - FIXED: idx is constant for the whole burst.
  - Beat counter increments on every handshake.
- Burst end is the WLAST handshake. err is set if:
  - WLAST arrives on a beat other than number AWLEN+1, or
  - more than AWLEN+1 beats arrive without WLAST. Beats beyond AWLEN+1 are dropped. The burst still ends only at WLAST.
  - On the WLAST handshake: WREADY=0 next cycle; state RESP.
- RESP:
  - BVALID=1, BID=captured AWID, BRESP = err ? 10 : 00.
  - Held stable until BREADY.
  - On the B handshake: BVALID=0 and state IDLE next cycle, so AWREADY=1.
- Latency:
  - AW handshake to WREADY: 1 cycle.
  - WLAST handshake to BVALID: 1 cycle.
  - B handshake to AWREADY: 1 cycle.
- A partial error does not roll back beats already written before the error was detected. Writes are suppressed only from detection onward. AWSIZE/AWBURST errors suppress every beat.
- WVALID in IDLE or RESP is ignored because WREADY=0.
- A debug read of a word written on the same edge returns the old value. The new value appears one cycle later.
- ARESET mid-burst: the FSM aborts to IDLE, no B is issued, memory is cleared.

Test Plan:
- AWADDR=0x8, AWLEN=3, INCR, AWSIZE=2, AWID=5; WDATA 0xA0..0xA3, WSTRB=0xF, WLAST on beat 4 -> mem[2..5]=0xA0..0xA3; BID=5, BRESP=00; BVALID 1 cycle after the WLAST handshake.
- FIXED burst, AWADDR=0x4, AWLEN=1; WDATA 0x11223344 with WSTRB=0xF, then 0xAABBCCDD with WSTRB=0x3 -> mem[1]=0x1122CCDD; BRESP=00.
- INCR, AWADDR=0x38 (idx 14), AWLEN=3 -> mem[14], mem[15] written; beats 3-4 dropped; BRESP=10.
- AWBURST=WRAP or AWSIZE=1 -> no memory change (dbg reads 0); BRESP=10; BID equals AWID.
- AWLEN=3 with WLAST asserted on beat 2 -> beats 1-2 written; BRESP=10 issued after beat 2. BREADY held low 5 cycles -> BVALID/BID/BRESP stable; AWREADY=0 until the B handshake.
- ARESET pulsed while in DATA after 1 beat -> all outputs 0 immediately, no BVALID, memory 0; AWREADY=1 one edge after release; a new burst then completes normally.

Source files
------------

// File: rtl/vgm_axi_write_slave.sv
// AXI4 write-channel responder backed by a small word-addressed memory.
// One AW burst in flight at a time; W beats are sunk into memory and a single
// B response is returned per burst. A sideband port reads memory directly.

// One byte lane of the backing memory: byte-wide write, registered debug read.
module vgm_axi_wr_lane #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // Storage and read register; reset clears every entry so benches start from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

module vgm_axi_write_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [ID_WIDTH-1:0]           AWID,
  input  logic [ADDR_WIDTH-1:0]         AWADDR,
  input  logic [7:0]                    AWLEN,
  input  logic [2:0]                    AWSIZE,
  input  logic [1:0]                    AWBURST,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [DATA_WIDTH-1:0]         WDATA,
  input  logic [DATA_WIDTH/8-1:0]       WSTRB,
  input  logic                          WLAST,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [ID_WIDTH-1:0]           BID,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_addr,
  output logic [DATA_WIDTH-1:0]         dbg_data
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int WSHIFT    = $clog2(NUM_LANES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  // Burst context captured at the AW handshake.
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                fixed;
    logic [7:0]          len;
  } aw_ctx_t;

  state_t                state_q, state_d;
  aw_ctx_t               ctx_q, ctx_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [8:0]            cnt_q, cnt_d;   // beats accepted so far, saturating
  logic                  err_q, err_d;
  logic                  mem_we;

  logic                  aw_hs, w_hs, b_hs;
  logic                  beyond, oor, attr_bad;

  logic [NUM_LANES-1:0][7:0] wdata_l, rdata_l;

  assign aw_hs    = AWVALID && AWREADY;
  assign w_hs     = WVALID && WREADY;
  assign b_hs     = BVALID && BREADY;
  // Beat past AWLEN+1, or word index outside the memory.
  assign beyond   = cnt_q > {1'b0, ctx_q.len};
  assign oor      = idx_q >= ADDR_WIDTH'(MEM_DEPTH);
  assign attr_bad = (AWSIZE != 3'(WSHIFT)) || (AWBURST != 2'b00 && AWBURST != 2'b01);

  // Next-state, burst bookkeeping and write enable.
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          ctx_d.id    = AWID;
          ctx_d.fixed = (AWBURST == 2'b00);
          ctx_d.len   = AWLEN;
          idx_d       = AWADDR >> WSHIFT;
          cnt_d       = '0;
          err_d       = attr_bad;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          // Beats before the error is seen still land; an early WLAST beat is kept.
          mem_we = !err_q && !oor && !beyond;
          if (oor || beyond || (WLAST && cnt_q != {1'b0, ctx_q.len})) err_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (!ctx_q.fixed) idx_d = idx_q + 1'b1;
          if (WLAST) state_d = RESP;
        end
      end
      RESP: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, context and registered AXI outputs derived from the next state.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      ctx_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= 2'b00;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      AWREADY <= (state_d == IDLE);
      WREADY  <= (state_d == DATA);
      BVALID  <= (state_d == RESP);
      if (state_q == DATA && state_d == RESP) begin
        BID   <= ctx_q.id;
        BRESP <= err_d ? 2'b10 : 2'b00;
      end
    end
  end

  assign wdata_l  = WDATA;
  assign dbg_data = rdata_l;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vgm_axi_wr_lane #(.DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk   (ACLK),
      .rst   (ARESET),
      .we    (mem_we && WSTRB[l]),
      .waddr (idx_q[IDX_W-1:0]),
      .wdata (wdata_l[l]),
      .raddr (dbg_addr),
      .rdata (rdata_l[l])
    );
  end

endmodule
